// File: rtl/param_fwft_fifo.sv
// ---------------------------------------------------------------------------
// param_fwft_fifo
//
// Synchronous first-word-fall-through FIFO. The oldest stored word is always
// presented on fifo_dout, so the consumer reads it and then pulses fifo_rd_en
// to pop it. A new word becomes visible one cycle after the write edge, with
// no read required.
//
// Parameters
//   DATA_WIDTH : width of each stored word
//   ADDR_WIDTH : pointer width; DEPTH = 2**ADDR_WIDTH entries
//   AF_THRESH  : fifo_almost_full asserts when fifo_count >= AF_THRESH
//   AE_THRESH  : fifo_almost_empty asserts when fifo_count <= AE_THRESH
//
// Ports
//   clk               : sole clock, rising edge
//   reset             : synchronous, active-high reset
//   fifo_din          : write data
//   fifo_wr_en        : write request
//   fifo_rd_en        : read request, pops the word currently on fifo_dout
//   fifo_dout         : oldest stored word, zero while empty
//   fifo_full         : DEPTH words stored
//   fifo_empty        : zero words stored
//   fifo_almost_full  : fill level at or above AF_THRESH
//   fifo_almost_empty : fill level at or below AE_THRESH
//   fifo_count        : current number of stored words, 0..DEPTH
//   fifo_overflow     : one-cycle pulse after a rejected write
//   fifo_underflow    : one-cycle pulse after a rejected read
// ---------------------------------------------------------------------------
module param_fwft_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_din,
  input  logic                  fifo_wr_en,
  input  logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  fifo_almost_full,
  output logic                  fifo_almost_empty,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  fifo_overflow,
  output logic                  fifo_underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]      count;

  logic wr_accept;
  logic rd_accept;

  // Status flags decode straight from the registered count so they always
  // agree with fifo_count in the same cycle.
  assign fifo_count        = count;
  assign fifo_full         = (count == DEPTH_C);
  assign fifo_empty        = (count == '0);
  assign fifo_almost_full  = (count >= AF_C);
  assign fifo_almost_empty = (count <= AE_C);

  // A read frees a slot at the same edge, so a full FIFO still accepts a
  // write when it is being popped in that cycle.
  assign rd_accept = fifo_rd_en && !fifo_empty;
  assign wr_accept = fifo_wr_en && (!fifo_full || rd_accept);

  // Fall-through output: zero when nothing is stored so stale memory never
  // leaks out after a drain or a reset.
  assign fifo_dout = fifo_empty ? '0 : mem[rd_ptr];

  // NOTE: the storage array has no reset; the empty flag masks its contents,
  // and leaving it unreset lets it map onto plain registers or RAM.
  always_ff @(posedge clk) begin
    if (wr_accept && !reset) begin
      mem[wr_ptr] <= fifo_din;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else begin
      // Pointers wrap naturally modulo DEPTH through their bit width.
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;

      if (wr_accept && !rd_accept) begin
        count <= count + 1'b1;
      end else if (rd_accept && !wr_accept) begin
        count <= count - 1'b1;
      end

      fifo_overflow  <= fifo_wr_en && !wr_accept;
      fifo_underflow <= fifo_rd_en && !rd_accept;
    end
  end

endmodule

// File: tb/tb_param_fwft_fifo.sv
// ---------------------------------------------------------------------------
// tb_param_fwft_fifo
//
// Directed bench for param_fwft_fifo at DEPTH=4, AF_THRESH=3, AE_THRESH=1.
// A table of per-cycle vectors walks fill, overflow, full read+write, drain
// across the pointer wrap, underflow and empty read+write. Hand-written
// sequences then cover reset with data stored and a streaming run checked
// against a queue model.
// ---------------------------------------------------------------------------
module tb_param_fwft_fifo;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] fifo_din;
  logic          fifo_wr_en;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_almost_full;
  logic          fifo_almost_empty;
  logic [AW:0]   fifo_count;
  logic          fifo_overflow;
  logic          fifo_underflow;

  int n_cmp = 0;
  int n_bad = 0;

  param_fwft_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_THRESH (3),
    .AE_THRESH (1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .fifo_din         (fifo_din),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_rd_en       (fifo_rd_en),
    .fifo_dout        (fifo_dout),
    .fifo_full        (fifo_full),
    .fifo_empty       (fifo_empty),
    .fifo_almost_full (fifo_almost_full),
    .fifo_almost_empty(fifo_almost_empty),
    .fifo_count       (fifo_count),
    .fifo_overflow    (fifo_overflow),
    .fifo_underflow   (fifo_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic [AW:0]   cnt;
    logic          empty;
    logic          full;
    logic          af;
    logic          ae;
    logic          ov;
    logic          un;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic wr, input logic rd, input int din,
                              input int dout, input int cnt,
                              input logic e, input logic f, input logic af,
                              input logic ae, input logic ov, input logic un);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = DW'(din); v.dout = DW'(dout);
    v.cnt = (AW+1)'(cnt); v.empty = e; v.full = f; v.af = af; v.ae = ae;
    v.ov = ov; v.un = un;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every output against an expected-state record.
  task automatic check_all(input string tag, input vec_t v);
    check({tag, " dout"},  32'(fifo_dout),         32'(v.dout));
    check({tag, " count"}, 32'(fifo_count),        32'(v.cnt));
    check({tag, " empty"}, 32'(fifo_empty),        32'(v.empty));
    check({tag, " full"},  32'(fifo_full),         32'(v.full));
    check({tag, " af"},    32'(fifo_almost_full),  32'(v.af));
    check({tag, " ae"},    32'(fifo_almost_empty), 32'(v.ae));
    check({tag, " ovf"},   32'(fifo_overflow),     32'(v.ov));
    check({tag, " unf"},   32'(fifo_underflow),    32'(v.un));
  endtask

  // Drive inputs, take one rising edge, then sample 1 time unit later.
  task automatic step(input logic rst, input logic wr, input logic rd,
                      input logic [DW-1:0] din);
    reset      = rst;
    fifo_wr_en = wr;
    fifo_rd_en = rd;
    fifo_din   = din;
    @(posedge clk);
    #1;
  endtask

  vec_t           rst_state;
  logic [DW-1:0]  model_q [$];

  initial begin
    //                  wr rd din dout cnt e  f  af ae ov un
    vecs[0]  = mk(1, 0, 20, 20, 1, 0, 0, 0, 1, 0, 0);  // first word falls through
    vecs[1]  = mk(1, 0, 76, 20, 2, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 34, 20, 3, 0, 0, 1, 0, 0, 0);  // almost full at 3
    vecs[3]  = mk(1, 0, 11, 20, 4, 0, 1, 1, 0, 0, 0);  // full
    vecs[4]  = mk(1, 0, 99, 20, 4, 0, 1, 1, 0, 1, 0);  // rejected write
    vecs[5]  = mk(0, 0,  0, 20, 4, 0, 1, 1, 0, 0, 0);  // overflow is one cycle
    vecs[6]  = mk(1, 1, 55, 76, 4, 0, 1, 1, 0, 0, 0);  // full read+write
    vecs[7]  = mk(0, 1,  0, 34, 3, 0, 0, 1, 0, 0, 0);
    vecs[8]  = mk(0, 1,  0, 11, 2, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 1,  0, 55, 1, 0, 0, 0, 1, 0, 0);  // read pointer wraps
    vecs[10] = mk(0, 1,  0,  0, 0, 1, 0, 0, 1, 0, 0);  // drained, dout zero
    vecs[11] = mk(0, 1,  0,  0, 0, 1, 0, 0, 1, 0, 1);  // rejected read
    vecs[12] = mk(0, 0,  0,  0, 0, 1, 0, 0, 1, 0, 0);  // underflow is one cycle
    vecs[13] = mk(1, 1,  7,  7, 1, 0, 0, 0, 1, 0, 1);  // empty read+write
    vecs[14] = mk(0, 0,  0,  7, 1, 0, 0, 0, 1, 0, 0);

    rst_state = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);

    // Reset with both requests asserted: reset must win.
    step(1'b1, 1'b1, 1'b1, 8'hA5);
    step(1'b1, 1'b1, 1'b1, 8'hA5);
    check_all("reset", rst_state);

    for (int i = 0; i < NVEC; i++) begin
      step(1'b0, vecs[i].wr, vecs[i].rd, vecs[i].din);
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset mid-operation with three words stored (7, 8, 9).
    step(1'b0, 1'b1, 1'b0, 8'd8);
    step(1'b0, 1'b1, 1'b0, 8'd9);
    check("pre-reset count", 32'(fifo_count), 32'd3);
    step(1'b1, 1'b1, 1'b1, 8'd66);
    check_all("mid reset", rst_state);
    step(1'b0, 1'b1, 1'b0, 8'd42);
    check_all("post reset write", mk(0, 0, 0, 42, 1, 0, 0, 0, 1, 0, 0));

    // Streaming run: preload two more words, then simultaneous read+write
    // for many cycles so both pointers wrap several times.
    model_q.push_back(8'd42);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, DW'(100 + i));
      model_q.push_back(DW'(100 + i));
    end
    for (int i = 0; i < 12; i++) begin
      logic [DW-1:0] d;
      d = DW'(i * 3 + 1);
      step(1'b0, 1'b1, 1'b1, d);
      void'(model_q.pop_front());
      model_q.push_back(d);
      check($sformatf("stream%0d dout", i), 32'(fifo_dout), 32'(model_q[0]));
      check($sformatf("stream%0d count", i), 32'(fifo_count), 32'd3);
    end
    // Drain and confirm order.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, '0);
      void'(model_q.pop_front());
      check($sformatf("drain%0d dout", i), 32'(fifo_dout),
            model_q.size() == 0 ? 32'd0 : 32'(model_q[0]));
    end
    check("final empty", 32'(fifo_empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/param_fwft_fifo.md
PARAM_FWFT_FIFO -- requirements
Module: param_fwft_fifo

Interface
REQ-001 Parameter DATA_WIDTH, 8, width of each stored word.
REQ-002 Parameter ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 Parameter AF_THRESH, DEPTH-2, fill level at or above which fifo_almost_full asserts.
REQ-004 Parameter AE_THRESH, 2, fill level at or below which fifo_almost_empty asserts.
REQ-005 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 Port reset  input  1  synchronous, active-high reset.
REQ-007 Port fifo_din  input  DATA_WIDTH  write data.
REQ-008 Port fifo_wr_en  input  1  write request.
REQ-009 Port fifo_rd_en  input  1  read request; pops the word currently on fifo_dout.
REQ-010 Port fifo_dout  output  DATA_WIDTH  oldest stored word (first-word-fall-through).
REQ-011 Port fifo_full  output  1  DEPTH words stored.
REQ-012 Port fifo_empty  output  1  zero words stored.
REQ-013 Port fifo_almost_full  output  1  count >= AF_THRESH.
REQ-014 Port fifo_almost_empty  output  1  count <= AE_THRESH.
REQ-015 Port fifo_count  output  ADDR_WIDTH+1  current number of stored words, 0..DEPTH.
REQ-016 Port fifo_overflow  output  1  one-cycle pulse: rejected write.
REQ-017 Port fifo_underflow  output  1  one-cycle pulse: rejected read.

Function
REQ-018 Storage SHALL be a DEPTH x DATA_WIDTH register array with ADDR_WIDTH-bit write and read pointers wrapping modulo DEPTH.
REQ-019 fifo_dout SHALL combinationally present mem[rd_ptr] while !fifo_empty, and all-zeros while fifo_empty.
REQ-020 A word written at rising edge k SHALL appear on fifo_dout with fifo_empty low in the cycle following edge k (one-cycle write-to-visible latency, no read required).
REQ-021 A write SHALL be accepted when fifo_wr_en=1 and (fifo_full=0 or an accepted read occurs in the same cycle).
REQ-022 A read SHALL be accepted when fifo_rd_en=1 and fifo_empty=0; the next word (or zero if the FIFO becomes empty) appears after that edge.
REQ-023 Simultaneous accepted read and write: both pointers advance, fifo_count unchanged, flags unchanged.
REQ-024 Empty with fifo_rd_en=1 and fifo_wr_en=1: read rejected (underflow pulse), write accepted, count becomes 1.
REQ-025 fifo_count SHALL be a registered counter: +1 on write-only, -1 on read-only, hold otherwise; full = (count==DEPTH), empty = (count==0).
REQ-026 fifo_almost_full and fifo_almost_empty SHALL be decoded from fifo_count in the same cycle as fifo_count.
REQ-027 fifo_overflow SHALL be registered high for exactly one cycle after an edge where fifo_wr_en=1 was rejected; memory and pointers unchanged.
REQ-028 fifo_underflow SHALL be registered high for exactly one cycle after an edge where fifo_rd_en=1 was rejected; pointers unchanged.
REQ-029 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; data order preserved across wrap.

Reset
REQ-030 With reset=1 at a rising edge: pointers=0, fifo_count=0, fifo_empty=1, fifo_full=0, fifo_almost_empty=1, fifo_almost_full=0, fifo_overflow=0, fifo_underflow=0, fifo_dout=0.
REQ-031 Reset SHALL take priority over concurrent fifo_wr_en/fifo_rd_en; memory contents need not be cleared.
REQ-032 Reset asserted mid-operation with data stored SHALL discard all contents; first post-reset write behaves per REQ-020.

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, DEPTH=4, AF_THRESH=3, AE_THRESH=1)
REQ-033 Write 20 once, no read -> next cycle fifo_dout=20, fifo_empty=0, fifo_count=1, fifo_almost_empty=1.
REQ-034 Write 20,76,34,11 then a fifth write 99 -> fifo_full=1, fifo_almost_full=1, fifo_count=4, fifo_overflow pulses once, fifo_dout stays 20.
REQ-035 From full, read four times -> fifo_dout sequence 20,76,34,11 then 0, fifo_empty=1; a fifth read pulses fifo_underflow once.
REQ-036 Full FIFO, simultaneous read+write of 55 -> fifo_count stays 4, no overflow, fifo_dout advances to 76; later drains ...,11,55 across pointer wrap.
REQ-037 Empty FIFO, simultaneous read+write of 7 -> fifo_underflow pulse, fifo_count=1, fifo_dout=7.
REQ-038 Three words stored, assert reset one cycle -> all outputs at REQ-030 values; next write 42 -> fifo_dout=42 one cycle later.
